// File: rtl/gru_sequence_controller.sv
// Runs one GRU layer over seq_len timesteps: collects x_t, fires the cell once per step,
// carries h between steps and hands the final h downstream. Optional cell watchdog: GRU_SEQ_TIMEOUT_EN.
module gru_sequence_controller #(
  parameter int D              = 128,
  parameter int H              = 256,
  parameter int DATA_WIDTH     = 16,
  parameter int SEQ_W          = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seq_start,
  input  logic [SEQ_W-1:0]        seq_len,
  input  logic [D*DATA_WIDTH-1:0] x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic [D*DATA_WIDTH-1:0] cell_x_t,
  output logic [H*DATA_WIDTH-1:0] cell_h_prev,
  output logic                    cell_start,
  input  logic [H*DATA_WIDTH-1:0] cell_h_t,
  input  logic                    cell_done,
  output logic [H*DATA_WIDTH-1:0] h_out,
  output logic                    h_out_valid,
  input  logic                    h_out_ready,
  output logic                    busy,
  output logic [SEQ_W-1:0]        step_count,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, WAIT_X, START_CELL, WAIT_CELL, EMIT} state_t;

  state_t                  state_q;
  logic [SEQ_W-1:0]        len_q, step_q, step_d;
  logic [D*DATA_WIDTH-1:0] x_q;
  logic [H*DATA_WIDTH-1:0] h_q, hp_q;
  logic                    done_q, done_rise;
  logic                    x_ready_q, start_q, vld_q, busy_q, err_q;

`ifdef GRU_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;
`endif

  assign step_d    = step_q + 1'b1;
  // Level-style done from the cell: only a fresh rising edge counts as completion.
  assign done_rise = cell_done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      step_q    <= '0;
      x_q       <= '0;
      h_q       <= '0;
      hp_q      <= '0;
      done_q    <= 1'b0;
      x_ready_q <= 1'b0;
      start_q   <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef GRU_SEQ_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      done_q  <= cell_done;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seq_start) begin
            len_q  <= seq_len;
            h_q    <= '0;
            step_q <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (seq_len == '0) begin
              state_q <= EMIT;
              vld_q   <= 1'b1;
            end else begin
              state_q   <= WAIT_X;
              x_ready_q <= 1'b1;
            end
          end
        end
        WAIT_X: begin
          if (x_valid) begin
            x_q       <= x_in;
            hp_q      <= h_q;
            x_ready_q <= 1'b0;
            start_q   <= 1'b1;
            state_q   <= START_CELL;
          end
        end
        START_CELL: begin
          state_q <= WAIT_CELL;
`ifdef GRU_SEQ_TIMEOUT_EN
          to_q    <= '0;
`endif
        end
        WAIT_CELL: begin
          if (done_rise) begin
            h_q    <= cell_h_t;
            step_q <= step_d;
            if (step_d == len_q) begin
              state_q <= EMIT;
              vld_q   <= 1'b1;
            end else begin
              state_q   <= WAIT_X;
              x_ready_q <= 1'b1;
            end
          end
`ifdef GRU_SEQ_TIMEOUT_EN
          // Give up on a hung cell; the sequence is abandoned without an output.
          else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (h_out_ready) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_ready     = x_ready_q;
  assign cell_start  = start_q;
  assign cell_x_t    = x_q;
  assign cell_h_prev = hp_q;
  assign h_out       = h_q;
  assign h_out_valid = vld_q;
  assign busy        = busy_q;
  assign step_count  = step_q;
  assign err         = err_q;

endmodule

// File: tb/tb_gru_sequence_controller.sv
// Self-checking bench: table vectors, random sequences against a running-sum model, corner cases.
module tb_gru_sequence_controller;
  localparam int D = 2, H = 2, DW = 16, SW = 16, TO = 16;
  localparam int VW = 2 * DW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          seq_start = 1'b0, x_valid = 1'b0, h_out_ready = 1'b0;
  logic [SW-1:0] seq_len = '0;
  logic [VW-1:0] x_in = '0;
  logic          x_ready, cell_start, cell_done, h_out_valid, busy, err;
  logic [VW-1:0] cell_x_t, cell_h_prev, cell_h_t, h_out;
  logic [SW-1:0] step_count;

  gru_sequence_controller #(.D(D), .H(H), .DATA_WIDTH(DW), .SEQ_W(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .seq_len(seq_len),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .cell_x_t(cell_x_t), .cell_h_prev(cell_h_prev), .cell_start(cell_start),
    .cell_h_t(cell_h_t), .cell_done(cell_done),
    .h_out(h_out), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
    .busy(busy), .step_count(step_count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] lo, hi;
    lo = a[DW-1:0] + b[DW-1:0];
    hi = a[VW-1:DW] + b[VW-1:DW];
    return {hi, lo};
  endfunction

  // Cell model: 5-cycle latency, h_t = h_prev + x, done is a level dropped on start.
  logic          cm_done = 1'b0, cm_busy = 1'b0;
  int            cm_cnt = 0;
  logic [VW-1:0] cm_h = '0;
  logic          manual = 1'b0, man_done = 1'b0;
  assign cell_done = manual ? man_done : cm_done;
  assign cell_h_t  = cm_h;

  always @(posedge clk) begin
    if (cell_start) begin
      cm_busy <= 1'b1;
      cm_cnt  <= 5;
      cm_done <= 1'b0;
      cm_h    <= vadd(cell_h_prev, cell_x_t);
    end else if (cm_busy) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) begin
        cm_busy <= 1'b0;
        cm_done <= 1'b1;
      end
    end
  end

  int   starts = 0, wide = 0;
  logic prev_st = 1'b0;
  always @(negedge clk) begin
    if (cell_start) begin
      starts <= starts + 1;
      if (prev_st) wide <= wide + 1;
    end
    prev_st <= cell_start;
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [VW-1:0] cur_xs [0:7];

  task automatic pulse_start(input int len);
    seq_len = SW'(len);
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
  endtask

  task automatic finish_emit(input string tg);
    h_out_ready = 1'b1;
    @(negedge clk);
    h_out_ready = 1'b0;
    chk({tg, "_idle"}, {h_out_valid, busy}, 0);
  endtask

  task automatic run_seq(input int len, input logic [VW-1:0] exp_h, input int xdly,
                         input int odly, input string tg);
    logic [VW-1:0] hrun;
    int   s0, n;
    logic ok;
    hrun = '0;
    s0   = starts;
    pulse_start(len);
    chk({tg, "_busy"}, busy, 1);
    if (len == 0) chk({tg, "_len0_vld"}, h_out_valid, 1);
    for (int k = 0; k < len; k++) begin
      n = 0;
      while (!x_ready && n < 200) begin @(negedge clk); n++; end
      chk({tg, "_xrdy"}, x_ready, 1);
      ok = 1'b1;
      for (int d = 0; d < xdly; d++) begin
        @(negedge clk);
        if (cell_start || !x_ready) ok = 1'b0;
      end
      if (xdly > 0) chk({tg, "_xdelay_hold"}, ok, 1);
      x_in = cur_xs[k];
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
      chk({tg, "_start"}, {cell_start, x_ready}, 2'b10);
      chk({tg, "_cell_x"}, cell_x_t, cur_xs[k]);
      chk({tg, "_cell_hp"}, cell_h_prev, hrun);
      hrun = vadd(hrun, cur_xs[k]);
    end
    n = 0;
    while (!h_out_valid && n < 200) begin @(negedge clk); n++; end
    chk({tg, "_vld"}, h_out_valid, 1);
    ok = 1'b1;
    for (int d = 0; d < odly; d++) begin
      if (!h_out_valid || h_out !== exp_h) ok = 1'b0;
      @(negedge clk);
    end
    if (odly > 0) chk({tg, "_out_stable"}, ok, 1);
    chk({tg, "_h_out"}, h_out, exp_h);
    chk({tg, "_model_h"}, h_out, hrun);
    chk({tg, "_steps"}, step_count, SW'(len));
    chk({tg, "_nstart"}, starts - s0, len);
    finish_emit(tg);
  endtask

  typedef struct {
    int                    len;
    logic [3:0][VW-1:0]    xs;
    logic [VW-1:0]         exp_h;
    int                    xdly;
    int                    odly;
  } vec_t;
  vec_t tbl [0:3];

  initial begin
    int n, len;
    int s0, s1;
    logic [VW-1:0] xv;
    logic saw_vld;

    tbl[0].len = 3; tbl[0].xdly = 0; tbl[0].odly = 0;
    tbl[0].xs = {32'h0, {16'd6, 16'd5}, {16'd4, 16'd3}, {16'd2, 16'd1}};
    tbl[0].exp_h = {16'd12, 16'd9};
    tbl[1].len = 0; tbl[1].xdly = 0; tbl[1].odly = 1;
    tbl[1].xs = '0;
    tbl[1].exp_h = '0;
    tbl[2].len = 2; tbl[2].xdly = 7; tbl[2].odly = 10;
    tbl[2].xs = {32'h0, 32'h0, {16'd1, 16'd1}, {16'hFFFF, 16'd7}};
    tbl[2].exp_h = {16'h0000, 16'd8};
    tbl[3].len = 1; tbl[3].xdly = 2; tbl[3].odly = 3;
    tbl[3].xs = {32'h0, 32'h0, 32'h0, {16'h7FFF, 16'h8000}};
    tbl[3].exp_h = {16'h7FFF, 16'h8000};

    #12;
    chk("reset_outs", {x_ready, cell_start, h_out_valid, busy, err}, 0);
    chk("reset_data", {step_count, h_out, cell_x_t, cell_h_prev}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) cur_xs[k] = tbl[i].xs[k];
      run_seq(tbl[i].len, tbl[i].exp_h, tbl[i].xdly, tbl[i].odly, $sformatf("tbl%0d", i));
    end

    // Random sequences; expected h is the per-lane sum of all inputs modulo 2^16.
    for (int r = 0; r < 8; r++) begin
      int s_lo, s_hi;
      len = $urandom_range(1, 6);
      s_lo = 0; s_hi = 0;
      for (int k = 0; k < len; k++) begin
        cur_xs[k] = $urandom;
        s_lo += int'(cur_xs[k][DW-1:0]);
        s_hi += int'(cur_xs[k][VW-1:DW]);
      end
      xv = {16'(s_hi % 65536), 16'(s_lo % 65536)};
      run_seq(len, xv, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    // Done stuck high from the previous run: only a fresh rising edge completes the step.
    manual = 1'b1; man_done = 1'b1;
    xv = {16'h1234, 16'h00AB};
    pulse_start(1);
    n = 0;
    while (!x_ready && n < 50) begin @(negedge clk); n++; end
    x_in = xv; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(9);
    repeat (5) @(negedge clk);
    chk("stuck_no_complete", {step_count, busy, x_ready, h_out_valid}, {16'd0, 3'b100});
    man_done = 1'b0;
    @(negedge clk);
    chk("stuck_low_step", step_count, 0);
    man_done = 1'b1;
    @(negedge clk);
    chk("stuck_edge_vld", {h_out_valid, step_count}, {1'b1, 16'd1});
    chk("stuck_h_out", h_out, xv);
    finish_emit("stuck");
    manual = 1'b0;

`ifdef GRU_SEQ_TIMEOUT_EN
    manual = 1'b1; man_done = 1'b0;
    pulse_start(1);
    n = 0;
    while (!x_ready && n < 50) begin @(negedge clk); n++; end
    x_in = xv; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    n = 0; saw_vld = 1'b0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
      if (h_out_valid) saw_vld = 1'b1;
    end
    chk("to_cycles", n, 17);
    chk("to_err", {err, busy, saw_vld}, 3'b100);
    pulse_start(0);
    chk("to_err_clear", err, 0);
    finish_emit("to_clr");
    manual = 1'b0;
`else
    chk("err_tied", err, 0);
`endif

    // Reset while the cell is in flight.
    cur_xs[0] = {16'h0055, 16'h0077};
    pulse_start(2);
    n = 0;
    while (!x_ready && n < 50) begin @(negedge clk); n++; end
    x_in = cur_xs[0]; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    s0 = starts;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {x_ready, cell_start, h_out_valid, busy, err}, 0);
    chk("mid_rst_data", {step_count, h_out, cell_x_t, cell_h_prev}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    s1 = starts;
    chk("mid_rst_quiet", {s1 - s0, 28'd0, busy, h_out_valid}, 0);
    cur_xs[0] = {16'h0102, 16'h0304};
    run_seq(1, {16'h0102, 16'h0304}, 0, 1, "post_rst");

    repeat (3) @(negedge clk);
    chk("start_width", wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
